// File: rtl/mem_write_monitor_pkg.sv
// Shared constants and state encoding for the memory-write test monitor.
package mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TOUT = 2'd3
  } mon_state_t;

  localparam logic [31:0] DEF_PASS_ADDR  = 32'd84;
  localparam logic [31:0] DEF_PASS_DATA  = 32'd7;
  localparam logic [31:0] DEF_ALLOW_ADDR = 32'd80;
  localparam logic [31:0] DEF_TIMEOUT    = 32'd2000;

  localparam int STORE_W = 16;
  localparam int CYCLE_W = 32;

  function automatic logic is_terminal(input mon_state_t s);
    return (s != ST_RUN);
  endfunction

endpackage

// File: rtl/mem_write_monitor_if.sv
// Processor data-memory store bus as seen by the monitor.
interface mem_write_monitor_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  modport master (output memwrite, output dataadr, output writedata);
  modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

// File: rtl/mem_write_monitor_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_r;

  // count register with saturation at all-ones
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (inc && (cnt_r != {WIDTH{1'b1}})) begin
      cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign count = cnt_r;

endmodule

// File: rtl/mem_write_monitor.sv
// Watches processor stores and latches a sticky pass/fail/timeout verdict,
// with run statistics and the offending store captured on failure.
module mem_write_monitor
  import mon_pkg::*;
#(
  parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
  parameter logic [31:0] ALLOW_ADDR = DEF_ALLOW_ADDR,
  parameter logic [31:0] TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_write_monitor_if.slave      bus,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [STORE_W-1:0]      store_count,
  output logic [CYCLE_W-1:0]      cycle_count,
  output logic [31:0]             err_addr,
  output logic [31:0]             err_data
);

  mon_state_t  state_r;
  mon_state_t  next_state_s;
  logic        store_inc_s;
  logic        cycle_inc_s;
  logic        capture_s;
  logic        done_r;
  logic        pass_r;
  logic        fail_r;
  logic        tout_r;
  logic [31:0] err_addr_r;
  logic [31:0] err_data_r;

  // next-state and counter enables; a verdict store outranks the timeout
  always_comb begin
    next_state_s = state_r;
    store_inc_s  = 1'b0;
    cycle_inc_s  = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      ST_RUN: begin
        cycle_inc_s = 1'b1;
        store_inc_s = bus.memwrite;
        if (bus.memwrite && (bus.dataadr == PASS_ADDR) && (bus.writedata == PASS_DATA)) begin
          next_state_s = ST_PASS;
        end else if (bus.memwrite && (bus.dataadr != ALLOW_ADDR)) begin
          next_state_s = ST_FAIL;
          capture_s    = 1'b1;
        end else if ((cycle_count + 32'd1) == TIMEOUT) begin
          next_state_s = ST_TOUT;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_PASS, ST_FAIL, ST_TOUT: begin
        next_state_s = state_r;
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // state register, verdict flags decoded from the incoming state, error capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      fail_r     <= 1'b0;
      tout_r     <= 1'b0;
      err_addr_r <= 32'd0;
      err_data_r <= 32'd0;
    end else begin
      state_r <= next_state_s;
      done_r  <= is_terminal(next_state_s);
      pass_r  <= (next_state_s == ST_PASS);
      fail_r  <= (next_state_s == ST_FAIL);
      tout_r  <= (next_state_s == ST_TOUT);
      if (capture_s) begin
        err_addr_r <= bus.dataadr;
        err_data_r <= bus.writedata;
      end else begin
        err_addr_r <= err_addr_r;
        err_data_r <= err_data_r;
      end
    end
  end

  sat_counter #(.WIDTH(STORE_W)) u_store_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (store_inc_s),
    .count (store_count)
  );

  sat_counter #(.WIDTH(CYCLE_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (cycle_inc_s),
    .count (cycle_count)
  );

  assign done     = done_r;
  assign pass     = pass_r;
  assign fail     = fail_r;
  assign timeout  = tout_r;
  assign err_addr = err_addr_r;
  assign err_data = err_data_r;

endmodule
